// File: rtl/m_ext_pkg.sv
// Shared RV32M/RV64M encodings and the decoded-control bundle used by the
// issue stage and its decoder.
package m_ext_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    UNIT_MUL     = 2'd0,
    UNIT_DIV     = 2'd1,
    UNIT_FAST    = 2'd2,
    UNIT_ILLEGAL = 2'd3
  } unit_e;

  typedef struct packed {
    logic  signed_a;
    logic  signed_b;
    logic  upper_rem;
    logic  word_op;
    unit_e unit;
  } op_ctrl_t;

endpackage

// File: rtl/m_op_decode.sv
// Combinational M-extension decoder: control bits, extended operands and the
// divide-by-zero / signed-overflow shortcut result.
module m_op_decode
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output op_ctrl_t        ctrl_o,
  output logic [XLEN-1:0] op_a_o,
  output logic [XLEN-1:0] op_b_o,
  output logic [XLEN-1:0] fast_result_o
);

  logic [6:0]      w_opcode;
  logic [6:0]      w_f7;
  logic [2:0]      w_f3;
  logic            w_is_m, w_is_w;
  logic            w_sa, w_sb, w_ur;
  logic            w_b_zero, w_ovf;
  logic [XLEN-1:0] w_a, w_b, w_fast_raw;
  logic            w_unused_fields;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_f7     = instr_i[31:25];
  assign w_unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  assign w_is_m = (w_opcode == OPC_OP) && (w_f7 == FUNCT7_MULDIV);
  assign w_is_w = (XLEN == 64) && (w_opcode == OPC_OP32) && (w_f7 == FUNCT7_MULDIV) &&
                  (w_f3[2] || (w_f3 == F3_MUL));

  always_comb begin
    {w_sa, w_sb, w_ur} = 3'b000;
    case (w_f3)
      F3_MUL:    {w_sa, w_sb, w_ur} = 3'b000;
      F3_MULH:   {w_sa, w_sb, w_ur} = 3'b111;
      F3_MULHSU: {w_sa, w_sb, w_ur} = 3'b101;
      F3_MULHU:  {w_sa, w_sb, w_ur} = 3'b001;
      F3_DIV:    {w_sa, w_sb, w_ur} = 3'b110;
      F3_DIVU:   {w_sa, w_sb, w_ur} = 3'b000;
      F3_REM:    {w_sa, w_sb, w_ur} = 3'b111;
      F3_REMU:   {w_sa, w_sb, w_ur} = 3'b001;
      default:   {w_sa, w_sb, w_ur} = 3'b000;
    endcase
  end

  // W-ops work on the low word, extended according to each operand's signedness
  assign w_a = w_is_w ? (w_sa ? XLEN'($signed(rs1_i[31:0])) : XLEN'(rs1_i[31:0])) : rs1_i;
  assign w_b = w_is_w ? (w_sb ? XLEN'($signed(rs2_i[31:0])) : XLEN'(rs2_i[31:0])) : rs2_i;

  assign w_b_zero = (w_b == '0);
  assign w_ovf    = w_sa && (w_is_w ? ((w_a[31:0] == 32'h8000_0000) && (w_b[31:0] == '1))
                                    : ((w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1)));

  always_comb begin
    w_fast_raw = '0;
    if (w_b_zero)  w_fast_raw = w_f3[1] ? w_a : '1;
    else if (w_ovf) w_fast_raw = w_f3[1] ? '0 : w_a;
  end

  assign fast_result_o = w_is_w ? XLEN'($signed(w_fast_raw[31:0])) : w_fast_raw;
  assign op_a_o = w_a;
  assign op_b_o = w_b;

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.signed_a  = w_sa;
    ctrl_o.signed_b  = w_sb;
    ctrl_o.upper_rem = w_ur;
    ctrl_o.word_op   = w_is_w;
    if (!(w_is_m || w_is_w))       ctrl_o.unit = UNIT_ILLEGAL;
    else if (!w_f3[2])             ctrl_o.unit = UNIT_MUL;
    else if (w_b_zero || w_ovf)    ctrl_o.unit = UNIT_FAST;
    else                           ctrl_o.unit = UNIT_DIV;
  end

endmodule

// File: rtl/m_issue_unit.sv
// RV32M/RV64M issue stage: decodes into a one-entry buffer and hands the
// instruction to the multiplier, divider or fast-result sink.
module m_issue_unit
  import m_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             mul_valid_o,
  input  logic             mul_ready_i,
  output logic             div_valid_o,
  input  logic             div_ready_i,
  output logic             fast_valid_o,
  input  logic             fast_ready_i,
  output logic [XLEN-1:0]  fast_result_o,
  output logic [XLEN-1:0]  op_a_o,
  output logic [XLEN-1:0]  op_b_o,
  output logic             signed_a_o,
  output logic             signed_b_o,
  output logic             upper_rem_o,
  output logic             word_op_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] illegal_tag_o
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e          r_state, w_state_nxt;
  op_ctrl_t        w_dec_ctrl, r_ctrl;
  logic [XLEN-1:0] w_dec_a, w_dec_b, w_dec_fast;
  logic [XLEN-1:0] r_op_a, r_op_b, r_fast;
  logic [TAG_W-1:0] r_tag, r_illegal_tag;
  logic            r_illegal;
  logic            w_full, w_fire, w_accept, w_load, w_illegal_acc;

  m_op_decode #(.XLEN(XLEN)) u_decode (
    .instr_i       (instr_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .ctrl_o        (w_dec_ctrl),
    .op_a_o        (w_dec_a),
    .op_b_o        (w_dec_b),
    .fast_result_o (w_dec_fast)
  );

  assign w_full        = (r_state == S_FULL);
  assign mul_valid_o   = w_full && (r_ctrl.unit == UNIT_MUL);
  assign div_valid_o   = w_full && (r_ctrl.unit == UNIT_DIV);
  assign fast_valid_o  = w_full && (r_ctrl.unit == UNIT_FAST);
  assign w_fire        = (mul_valid_o && mul_ready_i) || (div_valid_o && div_ready_i) ||
                         (fast_valid_o && fast_ready_i);
  assign instr_ready_o = !w_full || w_fire;
  assign w_accept      = instr_valid_i && instr_ready_o;
  assign w_load        = w_accept && (w_dec_ctrl.unit != UNIT_ILLEGAL);
  assign w_illegal_acc = w_accept && (w_dec_ctrl.unit == UNIT_ILLEGAL);

  always_comb begin
    w_state_nxt = r_state;
    if (w_load)      w_state_nxt = S_FULL;
    else if (w_fire) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Buffer only changes on a legal accept, so a stalled sink sees stable data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl        <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_fast        <= '0;
      r_tag         <= '0;
      r_illegal     <= 1'b0;
      r_illegal_tag <= '0;
    end else begin
      r_illegal <= w_illegal_acc;
      if (w_illegal_acc) r_illegal_tag <= tag_i;
      if (w_load) begin
        r_ctrl <= w_dec_ctrl;
        r_op_a <= w_dec_a;
        r_op_b <= w_dec_b;
        r_fast <= w_dec_fast;
        r_tag  <= tag_i;
      end
    end
  end

  assign fast_result_o = r_fast;
  assign op_a_o        = r_op_a;
  assign op_b_o        = r_op_b;
  assign signed_a_o    = r_ctrl.signed_a;
  assign signed_b_o    = r_ctrl.signed_b;
  assign upper_rem_o   = r_ctrl.upper_rem;
  assign word_op_o     = r_ctrl.word_op;
  assign tag_o         = r_tag;
  assign illegal_o     = r_illegal;
  assign illegal_tag_o = r_illegal_tag;

endmodule

// File: tb/tb_m_issue_unit.sv
// Bench for m_issue_unit: one XLEN=32 and one XLEN=64 instance, directed
// scenarios plus a randomized stream against a spec-level reference model.
`timescale 1ns/1ps
module tb_m_issue_unit;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel64;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] rs1, rs2;
  logic [4:0]  tag;
  logic        mul_rdy, div_rdy, fast_rdy;

  logic        r32, mv32, dv32, fv32, sa32, sb32, ur32, wo32, il32;
  logic [31:0] fr32, a32, b32;
  logic [4:0]  t32, it32;
  logic        r64, mv64, dv64, fv64, sa64, sb64, ur64, wo64, il64;
  logic [63:0] fr64, a64, b64;
  logic [4:0]  t64, it64;

  m_issue_unit #(.XLEN(32), .TAG_W(TAG_W)) u32 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(valid & ~sel64), .instr_ready_o(r32),
    .instr_i(instr), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .tag_i(tag),
    .mul_valid_o(mv32), .mul_ready_i(mul_rdy), .div_valid_o(dv32), .div_ready_i(div_rdy),
    .fast_valid_o(fv32), .fast_ready_i(fast_rdy), .fast_result_o(fr32),
    .op_a_o(a32), .op_b_o(b32), .signed_a_o(sa32), .signed_b_o(sb32),
    .upper_rem_o(ur32), .word_op_o(wo32), .tag_o(t32), .illegal_o(il32), .illegal_tag_o(it32));

  m_issue_unit #(.XLEN(64), .TAG_W(TAG_W)) u64 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(valid & sel64), .instr_ready_o(r64),
    .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag),
    .mul_valid_o(mv64), .mul_ready_i(mul_rdy), .div_valid_o(dv64), .div_ready_i(div_rdy),
    .fast_valid_o(fv64), .fast_ready_i(fast_rdy), .fast_result_o(fr64),
    .op_a_o(a64), .op_b_o(b64), .signed_a_o(sa64), .signed_b_o(sb64),
    .upper_rem_o(ur64), .word_op_o(wo64), .tag_o(t64), .illegal_o(il64), .illegal_tag_o(it64));

  logic        o_ready, o_il;
  logic [2:0]  o_vld;
  logic [3:0]  o_bits;
  logic [63:0] o_a, o_b, o_fr;
  logic [4:0]  o_tag, o_itag;
  assign o_ready = sel64 ? r64 : r32;
  assign o_vld   = sel64 ? {fv64, dv64, mv64} : {fv32, dv32, mv32};
  assign o_bits  = sel64 ? {sa64, sb64, ur64, wo64} : {sa32, sb32, ur32, wo32};
  assign o_a     = sel64 ? a64 : {32'h0, a32};
  assign o_b     = sel64 ? b64 : {32'h0, b32};
  assign o_fr    = sel64 ? fr64 : {32'h0, fr32};
  assign o_tag   = sel64 ? t64 : t32;
  assign o_il    = sel64 ? il64 : il32;
  assign o_itag  = sel64 ? it64 : it32;

  int compared = 0;
  int fails    = 0;

  typedef struct {
    int          unit;   // 0 mul, 1 div, 2 fast, 3 illegal
    bit          sa, sb, ur, w;
    logic [63:0] a, b, fast;
    logic [4:0]  tag;
  } exp_t;

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                                 input bit x64, input logic [4:0] t);
    exp_t e;
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7  = ins[31:25];
    logic [2:0] f3  = ins[14:12];
    logic [63:0] mask, nmask, minv;
    bit m_ok, w_ok, isrem;
    int n;
    e = '{unit: 3, sa: 0, sb: 0, ur: 0, w: 0, a: 64'h0, b: 64'h0, fast: 64'h0, tag: t};
    mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    m_ok = (opc == 7'h33) && (f7 == 7'h01);
    w_ok = x64 && (opc == 7'h3B) && (f7 == 7'h01) && ((f3 == 3'd0) || (f3 >= 3'd4));
    if (!m_ok && !w_ok) return e;
    e.w  = w_ok;
    e.sa = f3 inside {3'd1, 3'd2, 3'd4, 3'd6};
    e.sb = f3 inside {3'd1, 3'd4, 3'd6};
    e.ur = f3 inside {3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    if (w_ok) begin
      e.a = e.sa ? sx32(r1[31:0]) : {32'h0, r1[31:0]};
      e.b = e.sb ? sx32(r2[31:0]) : {32'h0, r2[31:0]};
    end else begin
      e.a = r1 & mask;
      e.b = r2 & mask;
    end
    if (f3 < 3'd4) begin
      e.unit = 0;
    end else begin
      n     = w_ok ? 32 : (x64 ? 64 : 32);
      nmask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      minv  = 64'h1 << (n - 1);
      isrem = (f3 >= 3'd6);
      e.unit = 2;
      if ((e.b & nmask) == 64'h0) e.fast = isrem ? e.a : nmask;
      else if (e.sa && ((e.a & nmask) == minv) && ((e.b & nmask) == nmask)) e.fast = isrem ? 64'h0 : e.a;
      else e.unit = 1;
      if (w_ok) e.fast = sx32(e.fast[31:0]);
      e.fast = e.fast & mask;
    end
    return e;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom % 7)
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return {32'h0, $urandom};
      5: return 64'(int'($urandom % 9) - 4);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int k = $urandom % 8;
    logic [2:0] f3 = 3'($urandom);
    if (k < 5)      return enc(7'h33, f3, 7'h01);
    else if (k < 7) return enc(7'h3B, f3, 7'h01);
    else            return $urandom;
  endfunction

  task automatic send(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    int n = 0;
    instr = i; rs1 = a; rs2 = b; tag = t; valid = 1'b1;
    #1;
    while (!o_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!o_ready) begin
      compared++; fails++;
      $display("FAIL send_timeout: instr_ready_o=%0b required 1 within 50 cycles", o_ready);
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      compared++;
      if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready x64=%0d: got %0b want 1", s, o_ready); end
      compared++;
      if ({o_vld, o_il, o_bits} !== 8'h00) begin fails++; $display("FAIL reset_ctrl x64=%0d: got %h want 00", s, {o_vld, o_il, o_bits}); end
      compared++;
      if ({o_a, o_b, o_fr, o_tag, o_itag} !== '0) begin fails++; $display("FAIL reset_data x64=%0d: a=%h b=%h fr=%h tag=%h itag=%h want 0", s, o_a, o_b, o_fr, o_tag, o_itag); end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mulhsu();
    sel64 = 1'b0; mul_rdy = 1'b1; div_rdy = 1'b0; fast_rdy = 1'b0;
    @(negedge clk);
    send(enc(7'h33, 3'b010, 7'h01), 64'hFFFF_FFFF, 64'd2, 5'd7);
    compared++;
    if (o_vld !== 3'b001) begin fails++; $display("FAIL mulhsu_valid: got %b want 001", o_vld); end
    compared++;
    if (o_bits !== 4'b1010) begin fails++; $display("FAIL mulhsu_bits: got %b want 1010", o_bits); end
    compared++;
    if (o_a !== 64'hFFFF_FFFF || o_b !== 64'd2 || o_tag !== 5'd7) begin fails++; $display("FAIL mulhsu_data: a=%h b=%h tag=%0d want ffffffff 2 7", o_a, o_b, o_tag); end
    @(posedge clk); #1;
    compared++;
    if (o_vld !== 3'b000 || o_ready !== 1'b1) begin fails++; $display("FAIL mulhsu_drain: vld=%b ready=%b want 000 1", o_vld, o_ready); end
  endtask

  task automatic test_fast();
    sel64 = 1'b0; mul_rdy = 1'b0; div_rdy = 1'b0; fast_rdy = 1'b1;
    @(negedge clk);
    send(enc(7'h33, 3'b100, 7'h01), 64'h8000_0000, 64'hFFFF_FFFF, 5'd1);
    compared++;
    if (o_vld !== 3'b100 || o_fr !== 64'h8000_0000) begin fails++; $display("FAIL div_ovf: vld=%b fr=%h want 100 80000000", o_vld, o_fr); end
    send(enc(7'h33, 3'b110, 7'h01), 64'h8000_0000, 64'hFFFF_FFFF, 5'd2);
    compared++;
    if (o_vld !== 3'b100 || o_fr !== 64'h0 || o_tag !== 5'd2) begin fails++; $display("FAIL rem_ovf: vld=%b fr=%h tag=%0d want 100 0 2", o_vld, o_fr, o_tag); end
    send(enc(7'h33, 3'b101, 7'h01), 64'h55, 64'h0, 5'd3);
    compared++;
    if (o_vld !== 3'b100 || o_fr !== 64'hFFFF_FFFF) begin fails++; $display("FAIL divu_zero: vld=%b fr=%h want 100 ffffffff", o_vld, o_fr); end
    send(enc(7'h33, 3'b111, 7'h01), 64'h1234, 64'h0, 5'd4);
    compared++;
    if (o_vld !== 3'b100 || o_fr !== 64'h1234) begin fails++; $display("FAIL remu_zero: vld=%b fr=%h want 100 1234", o_vld, o_fr); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    sel64 = 1'b0; mul_rdy = 1'b0; div_rdy = 1'b0; fast_rdy = 1'b0;
    @(negedge clk);
    send(enc(7'h33, 3'b100, 7'h01), 64'd100, 64'd7, 5'd9);
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (o_vld !== 3'b010 || o_a !== 64'd100 || o_tag !== 5'd9 || o_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold c=%0d: vld=%b a=%0d tag=%0d ready=%b want 010 100 9 0", c, o_vld, o_a, o_tag, o_ready);
      end
      @(posedge clk); #1;
    end
    div_rdy = 1'b1; mul_rdy = 1'b1;
    instr = enc(7'h33, 3'b000, 7'h01); rs1 = 64'd6; rs2 = 64'd5; tag = 5'd12; valid = 1'b1;
    #1;
    compared++;
    if (o_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", o_ready); end
    @(posedge clk); #1;
    valid = 1'b0; div_rdy = 1'b0;
    compared++;
    if (o_vld !== 3'b001 || o_tag !== 5'd12 || o_a !== 64'd6) begin fails++; $display("FAIL b2b_issue: vld=%b tag=%0d a=%0d want 001 12 6", o_vld, o_tag, o_a); end
    @(posedge clk); #1;
    mul_rdy = 1'b0;
  endtask

  task automatic test_illegal();
    sel64 = 1'b0; mul_rdy = 1'b1; div_rdy = 1'b1; fast_rdy = 1'b1;
    @(negedge clk);
    send(enc(7'h3B, 3'b000, 7'h01), 64'd1, 64'd2, 5'h11);
    compared++;
    if (o_il !== 1'b1 || o_itag !== 5'h11 || o_vld !== 3'b000) begin fails++; $display("FAIL ill_w32: il=%b itag=%h vld=%b want 1 11 000", o_il, o_itag, o_vld); end
    @(posedge clk); #1;
    compared++;
    if (o_il !== 1'b0) begin fails++; $display("FAIL ill_pulse: il=%b want 0", o_il); end
    sel64 = 1'b1;
    send(enc(7'h3B, 3'b001, 7'h01), 64'd1, 64'd2, 5'h0A);
    compared++;
    if (o_il !== 1'b1 || o_itag !== 5'h0A || o_vld !== 3'b000) begin fails++; $display("FAIL ill_w64: il=%b itag=%h vld=%b want 1 0a 000", o_il, o_itag, o_vld); end
    send(enc(7'h3B, 3'b100, 7'h01), 64'h0000_0000_FFFF_FFF8, 64'd2, 5'h05);
    compared++;
    if (o_vld !== 3'b010 || o_a !== 64'hFFFF_FFFF_FFFF_FFF8 || o_bits[0] !== 1'b1 || o_il !== 1'b0) begin
      fails++; $display("FAIL divw: vld=%b a=%h word=%b il=%b want 010 fffffffffffffff8 1 0", o_vld, o_a, o_bits[0], o_il);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    sel64 = 1'b0; mul_rdy = 1'b0; div_rdy = 1'b0; fast_rdy = 1'b0;
    @(negedge clk);
    send(enc(7'h33, 3'b100, 7'h01), 64'd50, 64'd3, 5'd3);
    #1 rst = 1'b1;
    #1;
    compared++;
    if (o_vld !== 3'b000 || o_ready !== 1'b1) begin fails++; $display("FAIL async_rst: vld=%b ready=%b want 000 1", o_vld, o_ready); end
    #1 rst = 1'b0;
    div_rdy = 1'b1; mul_rdy = 1'b1; fast_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      compared++;
      if (o_vld !== 3'b000 || o_ready !== 1'b1) begin fails++; $display("FAIL rst_stale c=%0d: vld=%b ready=%b want 000 1", c, o_vld, o_ready); end
    end
  endtask

  task automatic test_random(input bit x64, input int cycles);
    exp_t pend[$];
    exp_t e;
    bit   exp_ill = 0;
    logic [4:0] exp_itag = '0;
    bit   fire, exp_ready;
    logic [2:0] want_vld;
    sel64 = x64; valid = 1'b0;
    @(negedge clk);
    repeat (cycles) begin
      want_vld = (pend.size() != 0) ? 3'(1 << pend[0].unit) : 3'b000;
      compared++;
      if (o_vld !== want_vld) begin fails++; $display("FAIL rnd_vld x64=%0d: got %b want %b", x64, o_vld, want_vld); end
      if (pend.size() != 0) begin
        compared++;
        if (o_a !== pend[0].a || o_b !== pend[0].b || o_tag !== pend[0].tag ||
            o_bits !== {pend[0].sa, pend[0].sb, pend[0].ur, pend[0].w}) begin
          fails++; $display("FAIL rnd_data x64=%0d: a=%h b=%h tag=%h bits=%b want %h %h %h %b", x64, o_a, o_b, o_tag, o_bits,
                            pend[0].a, pend[0].b, pend[0].tag, {pend[0].sa, pend[0].sb, pend[0].ur, pend[0].w});
        end
        if (pend[0].unit == 2) begin
          compared++;
          if (o_fr !== pend[0].fast) begin fails++; $display("FAIL rnd_fast x64=%0d: got %h want %h", x64, o_fr, pend[0].fast); end
        end
      end
      compared++;
      if (o_il !== exp_ill || (exp_ill && o_itag !== exp_itag)) begin
        fails++; $display("FAIL rnd_ill x64=%0d: il=%b itag=%h want %b %h", x64, o_il, o_itag, exp_ill, exp_itag);
      end
      valid = ($urandom % 4) != 0;
      instr = rand_instr(); rs1 = rand_op(); rs2 = rand_op(); tag = 5'($urandom);
      mul_rdy = ($urandom % 10) < 7; div_rdy = ($urandom % 10) < 7; fast_rdy = ($urandom % 10) < 7;
      #1;
      fire = (pend.size() != 0) &&
             ((pend[0].unit == 0 && mul_rdy) || (pend[0].unit == 1 && div_rdy) || (pend[0].unit == 2 && fast_rdy));
      exp_ready = (pend.size() == 0) || fire;
      compared++;
      if (o_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready x64=%0d: got %b want %b", x64, o_ready, exp_ready); end
      @(posedge clk);
      exp_ill = 0;
      if (fire) void'(pend.pop_front());
      if (valid && exp_ready) begin
        e = model(instr, rs1, rs2, x64, tag);
        if (e.unit == 3) begin exp_ill = 1; exp_itag = tag; end
        else pend.push_back(e);
      end
      @(negedge clk);
    end
    valid = 1'b0; mul_rdy = 1'b1; div_rdy = 1'b1; fast_rdy = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sel64 = 1'b0; valid = 1'b0; instr = '0; rs1 = '0; rs2 = '0; tag = '0;
    mul_rdy = 1'b0; div_rdy = 1'b0; fast_rdy = 1'b0;
    #2;
    test_reset();
    test_mulhsu();
    test_fast();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    test_random(1'b0, 800);
    test_random(1'b1, 800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
